// File: rtl/ff_stim_if.sv
// ff_stim_if -- handshake and stimulus bundle for ff_stim_gen.
//
// Purpose: groups the request inputs (start/abort plus the run
// configuration) and the stimulus outputs that drive a single-bit flop
// under test.
//   master : the side issuing requests and observing the stimulus
//   slave  : the stimulus generator itself
// Signals:
//   start, abort          request controls
//   pattern[WIDTH]        bits to play, MSB first
//   repeat_n[CNT_W]       extra passes
//   hold_n[4]             DUT reset cycles before the pattern
//   lfsr_sel              (only with FF_STIM_LFSR_EN) pick LFSR source
//   d_out, dut_rst, exp_q stimulus to the flop and its expected q
//   busy, done            run status
// Optional macro: FF_STIM_LFSR_EN adds lfsr_sel.
`timescale 1ns/1ps
interface ff_stim_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [3:0]       hold_n;
`ifdef FF_STIM_LFSR_EN
  logic             lfsr_sel;
`endif
  logic             d_out;
  logic             dut_rst;
  logic             exp_q;
  logic             busy;
  logic             done;

`ifdef FF_STIM_LFSR_EN
  modport master (
    output start, abort, pattern, repeat_n, hold_n, lfsr_sel,
    input  d_out, dut_rst, exp_q, busy, done
  );
  modport slave (
    input  start, abort, pattern, repeat_n, hold_n, lfsr_sel,
    output d_out, dut_rst, exp_q, busy, done
  );
`else
  modport master (
    output start, abort, pattern, repeat_n, hold_n,
    input  d_out, dut_rst, exp_q, busy, done
  );
  modport slave (
    input  start, abort, pattern, repeat_n, hold_n,
    output d_out, dut_rst, exp_q, busy, done
  );
`endif
endinterface

// File: rtl/ff_stim_gen.sv
// ff_stim_gen -- stimulus sequencer for a single-bit flop under test.
//
// Purpose: on an accepted start, holds the flop in reset for hold cycles,
// then plays a latched WIDTH-bit pattern MSB first, (repeat_n+1) times
// back to back, then pulses done for one cycle. exp_q is the golden
// output of an ideal D flop with synchronous active-high reset.
// Ports:
//   clk   clock, all state on posedge
//   rst   synchronous active-low reset of this block
//   bus   ff_stim_if slave modport (start/abort/config in, stimulus out)
// Optional macro: FF_STIM_LFSR_EN -- adds lfsr_sel; when latched high,
// SHIFT bits come from a 16-bit Galois LFSR (taps 0xB400, seed 0xACE1).
`timescale 1ns/1ps
module ff_stim_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic     clk,
  input  logic     rst,
  ff_stim_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] pattern_reg;
  logic [WIDTH-1:0] shift_reg;   // remaining bits of the current pass, MSB next
  logic [CNT_W-1:0] rep_reg;     // passes still to go after the current one
  logic [3:0]       hold_reg;    // RESET cycles still to go after the current one
  logic [IDX_W-1:0] idx_reg;     // index of the bit currently on d_out
  logic             d_out_reg;
  logic             dut_rst_reg;
  logic             exp_q_reg;
  logic             busy_reg;
  logic             done_reg;

  // Bit emitted at the start of a pass, and the bit following the current one.
  logic first_bit;
  logic next_bit;

`ifdef FF_STIM_LFSR_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic        lfsr_sel_reg;
  logic [15:0] lfsr_reg;        // state whose bit 0 is emitted next
  logic [15:0] lfsr_next;
  logic        emit_bit;        // a new SHIFT bit is being registered this edge

  assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);

  always_comb begin
    emit_bit = 1'b0;
    if (state_reg == S_RESET && !bus.abort && hold_reg == 4'd0)
      emit_bit = 1'b1;
    if (state_reg == S_SHIFT && !bus.abort &&
        !(idx_reg == LAST_IDX && rep_reg == '0))
      emit_bit = 1'b1;
  end

  always_comb begin
    first_bit = lfsr_sel_reg ? lfsr_reg[0] : pattern_reg[WIDTH-1];
    next_bit  = lfsr_sel_reg ? lfsr_reg[0] : shift_reg[WIDTH-1];
  end

  // The LFSR runs freely across passes; it is reseeded only by a new start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_sel_reg <= 1'b0;
      lfsr_reg     <= LFSR_SEED;
    end else if (state_reg == S_IDLE && bus.start) begin
      lfsr_sel_reg <= bus.lfsr_sel;
      lfsr_reg     <= LFSR_SEED;
    end else if (emit_bit) begin
      lfsr_reg     <= lfsr_next;
    end
  end
`else
  always_comb begin
    first_bit = pattern_reg[WIDTH-1];
    next_bit  = shift_reg[WIDTH-1];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      pattern_reg <= '0;
      shift_reg   <= '0;
      rep_reg     <= '0;
      hold_reg    <= '0;
      idx_reg     <= '0;
      d_out_reg   <= 1'b0;
      dut_rst_reg <= 1'b1;
      exp_q_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      // Ideal flop model fed by the stimulus currently being presented.
      exp_q_reg <= dut_rst_reg ? 1'b0 : d_out_reg;
      done_reg  <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            state_reg   <= S_RESET;
            pattern_reg <= bus.pattern;
            rep_reg     <= bus.repeat_n;
            // hold_n of 0 behaves as 1; store cycles remaining after this one.
            hold_reg    <= (bus.hold_n == 4'd0) ? 4'd0 : bus.hold_n - 4'd1;
            idx_reg     <= '0;
            busy_reg    <= 1'b1;
            dut_rst_reg <= 1'b1;
            d_out_reg   <= 1'b0;
          end
        end

        S_RESET: begin
          if (bus.abort) begin
            state_reg   <= S_IDLE;
            busy_reg    <= 1'b0;
            dut_rst_reg <= 1'b1;
            d_out_reg   <= 1'b0;
            rep_reg     <= '0;
            hold_reg    <= '0;
            idx_reg     <= '0;
          end else if (hold_reg == 4'd0) begin
            state_reg   <= S_SHIFT;
            idx_reg     <= '0;
            dut_rst_reg <= 1'b0;
            d_out_reg   <= first_bit;
            shift_reg   <= pattern_reg << 1;
          end else begin
            hold_reg    <= hold_reg - 4'd1;
          end
        end

        S_SHIFT: begin
          if (bus.abort) begin
            state_reg   <= S_IDLE;
            busy_reg    <= 1'b0;
            dut_rst_reg <= 1'b1;
            d_out_reg   <= 1'b0;
            rep_reg     <= '0;
            hold_reg    <= '0;
            idx_reg     <= '0;
          end else if (idx_reg == LAST_IDX) begin
            if (rep_reg == '0) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              d_out_reg <= 1'b0;
            end else begin
              // Next pass starts immediately, no gap cycle.
              rep_reg   <= rep_reg - 1'b1;
              idx_reg   <= '0;
              d_out_reg <= first_bit;
              shift_reg <= pattern_reg << 1;
            end
          end else begin
            idx_reg   <= idx_reg + 1'b1;
            d_out_reg <= next_bit;
            shift_reg <= shift_reg << 1;
          end
        end

        S_DONE: begin
          state_reg   <= S_IDLE;
          dut_rst_reg <= 1'b1;
          d_out_reg   <= 1'b0;
        end

        default: begin
          state_reg   <= S_IDLE;
          busy_reg    <= 1'b0;
          dut_rst_reg <= 1'b1;
          d_out_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.d_out   = d_out_reg;
  assign bus.dut_rst = dut_rst_reg;
  assign bus.exp_q   = exp_q_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_ff_stim_gen.sv
// tb_ff_stim_gen -- bench for ff_stim_gen.
// A run-level model derives every cycle's outputs from the time elapsed
// since the accepted start (reset window, bit stream, done slot); a
// compare process checks the DUT against it on every negedge. Directed
// scenarios add literal expectations; a random phase follows.
`timescale 1ns/1ps
module tb_ff_stim_gen;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ff_stim_if #(.WIDTH(W), .CNT_W(CW)) bus();

  ff_stim_gen #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  int   m_t = 0;      // cycles since accepted start (0 = no run)
  int   m_hold = 1;
  int   m_len = 0;
  bit   m_bits[$];    // whole bit stream of the run
  logic e_d = 1'b0, e_rst = 1'b1, e_q = 1'b0, e_busy = 1'b0, e_done = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) begin : model
    logic         pq;
    logic [15:0]  s;
    logic [W-1:0] p;
    bit           use_lfsr;
    pq = e_rst ? 1'b0 : e_d;
    if (!rst) begin
      m_t = 0;
      pq  = 1'b0;
    end else if (m_t == 0) begin
      if (bus.start) begin
        m_hold = (bus.hold_n == 4'd0) ? 1 : int'(bus.hold_n);
        m_len  = W * (int'(bus.repeat_n) + 1);
        p = bus.pattern;
        use_lfsr = 1'b0;
`ifdef FF_STIM_LFSR_EN
        use_lfsr = bus.lfsr_sel;
`endif
        s = 16'hACE1;
        m_bits.delete();
        for (int k = 0; k < m_len; k++) begin
          if (use_lfsr) begin
            m_bits.push_back(s[0]);
            s = lfsr_step(s);
          end else begin
            m_bits.push_back(p[W-1-(k % W)]);
          end
        end
        m_t = 1;
      end
    end else if (m_t <= m_hold + m_len) begin
      if (bus.abort) m_t = 0;
      else m_t++;
    end else begin
      m_t = 0;
    end
    e_q = pq;
    if (m_t == 0) begin
      e_d = 0; e_rst = 1; e_busy = 0; e_done = 0;
    end else if (m_t <= m_hold) begin
      e_d = 0; e_rst = 1; e_busy = 1; e_done = 0;
    end else if (m_t <= m_hold + m_len) begin
      e_d = m_bits[m_t - m_hold - 1]; e_rst = 0; e_busy = 1; e_done = 0;
    end else begin
      e_d = 0; e_rst = 0; e_busy = 0; e_done = 1;
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    total++;
    if ({bus.d_out, bus.dut_rst, bus.exp_q, bus.busy, bus.done} !==
        {e_d, e_rst, e_q, e_busy, e_done}) begin
      bad++;
      $display("FAIL model_cycle t=%0t got d/rst/q/busy/done=%b%b%b%b%b want %b%b%b%b%b",
               $time, bus.d_out, bus.dut_rst, bus.exp_q, bus.busy, bus.done,
               e_d, e_rst, e_q, e_busy, e_done);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, got, got, want, want);
    end else begin
      $display("check %s = 0x%0h ok", name, got);
    end
  endtask

  task automatic chk_idle(input string name);
    chk(name, int'({bus.d_out, bus.dut_rst, bus.exp_q, bus.busy, bus.done}), 5'b01000);
  endtask

  // Called at a negedge; returns at the negedge showing the first RESET cycle.
  task automatic start_run(input logic [W-1:0] pat, input int rep, input int hold);
    bus.pattern  = pat;
    bus.repeat_n = CW'(rep);
    bus.hold_n   = 4'(hold);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    chk("first_reset_busy", int'(bus.busy & bus.dut_rst), 1);
  endtask

  task automatic capture(input int ncyc, output int nrst, output logic [127:0] bits,
                         output int nbits, output logic [127:0] qbits,
                         output int done_at, output int ndone);
    bit prev_bit;
    prev_bit = 1'b0;
    nrst = 0; bits = '0; nbits = 0; qbits = '0; done_at = -1; ndone = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (prev_bit) qbits = {qbits[126:0], bus.exp_q};
      prev_bit = 1'b0;
      if (bus.busy && bus.dut_rst) nrst++;
      if (bus.busy && !bus.dut_rst) begin
        bits = {bits[126:0], bus.d_out};
        nbits++;
        prev_bit = 1'b1;
      end
      if (bus.done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nrst, nbits, done_at, ndone;
    logic [127:0] bits, qbits;
    bus.start = 1'b0; bus.abort = 1'b0; bus.pattern = '0;
    bus.repeat_n = '0; bus.hold_n = '0;
`ifdef FF_STIM_LFSR_EN
    bus.lfsr_sel = 1'b0;
`endif
    // 1: reset then idle
    repeat (3) @(negedge clk);
    chk_idle("in_reset");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle("idle_after_reset");
    end

    // 2: A5, one pass, hold 2
    start_run(8'hA5, 0, 2);
    capture(14, nrst, bits, nbits, qbits, done_at, ndone);
    chk("s2_reset_cycles", nrst, 2);
    chk("s2_nbits", nbits, 8);
    chk("s2_bits", int'(bits[7:0]), 8'hA5);
    chk("s2_expq_bits", int'(qbits[7:0]), 8'hA5);
    chk("s2_done_at", done_at, 10);
    chk("s2_done_count", ndone, 1);

    // 3: F0, three passes, hold 0 -> 1
    start_run(8'hF0, 2, 0);
    capture(30, nrst, bits, nbits, qbits, done_at, ndone);
    chk("s3_reset_cycles", nrst, 1);
    chk("s3_nbits", nbits, 24);
    chk("s3_bits", int'(bits[23:0]), 24'hF0F0F0);
    chk("s3_done_at", done_at, 25);
    chk("s3_done_count", ndone, 1);

    // 4: abort on 4th SHIFT cycle, then immediate restart
    start_run(8'hFF, 0, 1);
    repeat (4) @(negedge clk);
    chk("s4_in_shift", int'(bus.busy & ~bus.dut_rst & bus.d_out), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("s4_after_abort_dout_rst_busy_done",
        int'({bus.d_out, bus.dut_rst, bus.busy, bus.done}), 4'b0100);
    start_run(8'hFF, 0, 1);
    capture(12, nrst, bits, nbits, qbits, done_at, ndone);
    chk("s4_restart_nbits", nbits, 8);
    chk("s4_restart_done_count", ndone, 1);

    // 5: start held high during a run is ignored; rst mid-run
    bus.pattern = 8'h3C; bus.repeat_n = 4'd1; bus.hold_n = 4'd3; bus.start = 1'b1;
    @(negedge clk);
    capture(20, nrst, bits, nbits, qbits, done_at, ndone);
    bus.start = 1'b0;
    chk("s5_nbits", nbits, 16);
    chk("s5_bits", int'(bits[15:0]), 16'h3C3C);
    chk("s5_done_at", done_at, 19);
    chk("s5_done_count", ndone, 1);
    start_run(8'h3C, 1, 3);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("s5_midrun_reset");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle("s5_idle_after_reset");
    end

`ifdef FF_STIM_LFSR_EN
    // 6: LFSR source, same sequence on two starts
    bus.lfsr_sel = 1'b1;
    for (int r = 0; r < 2; r++) begin
      start_run(8'h00, 0, 0);
      capture(12, nrst, bits, nbits, qbits, done_at, ndone);
      chk("s6_lfsr_bits", int'(bits[7:0]), 8'h87);
      chk("s6_done_at", done_at, 9);
    end
    bus.lfsr_sel = 1'b0;
`endif

    // random phase, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      bus.start    = ($urandom_range(0, 5) == 0);
      bus.abort    = ($urandom_range(0, 39) == 0);
      bus.pattern  = W'($urandom);
      bus.repeat_n = CW'($urandom_range(0, 3));
      bus.hold_n   = 4'($urandom);
`ifdef FF_STIM_LFSR_EN
      bus.lfsr_sel = 1'($urandom);
`endif
      rst = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ff_stim_gen.md
Name: ff_stim_gen

Overview:
- Synthesizable stimulus sequencer that drives a single-bit flip-flop under test.
- Outputs: the flop's data input (d_out), its active-high reset (dut_rst), and a golden expected-q model (exp_q).
- Plays a programmed bit pattern one or more times, then signals completion.
- Sits in front of the flop and its assertion checker, so benches no longer hand-code d/rst waveforms.

Parameters:
- WIDTH, 8: pattern length in bits, one bit per cycle.
- CNT_W, 4: width of the repeat count.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset for this block.
- start  input  1  one-cycle request; sampled only in IDLE.
- abort  input  1  cancels a run in progress.
- pattern  input  WIDTH  bits to play, MSB first; latched on accepted start.
- repeat_n  input  CNT_W  extra passes; total passes = repeat_n+1; latched on start.
- hold_n  input  4  DUT reset cycles before the pattern; 0 treated as 1; latched on start.
- d_out  output  1  data to flop under test.
- dut_rst  output  1  active-high reset to flop under test.
- exp_q  output  1  expected flop q, one cycle behind d_out.
- busy  output  1  high in RESET and SHIFT.
- done  output  1  one-cycle pulse at end of a completed run.

Behaviour:
- All outputs are registered. When rst=0 at a posedge, the block enters IDLE with d_out=0, dut_rst=1, exp_q=0, busy=0, done=0, and all counters at 0. This applies mid-run too: the run is discarded with no done pulse.
- IDLE: d_out=0, dut_rst=1.
  - start=1 latches pattern, repeat_n and hold_n (0 becomes 1) and goes to RESET.
  - start=0 stays in IDLE.
- RESET: dut_rst=1, d_out=0, busy=1.
  - Stays exactly hold cycles, then goes to SHIFT with bit index 0.
- SHIFT: dut_rst=0, busy=1; d_out = pattern[WIDTH-1-idx].
  - Each cycle idx increments.
  - At idx=WIDTH-1, if the remaining repeat count is 0, go to DONE. Otherwise decrement it, reset idx to 0 and stay in SHIFT. There is no gap cycle between passes.
- DONE: done=1 for exactly one cycle, dut_rst=0, d_out=0, busy=0; then IDLE, where dut_rst returns to 1.
- Latency:
  - First RESET cycle outputs appear the cycle after start is accepted.
  - First pattern bit appears hold cycles after that.
  - A full run is hold + WIDTH*(repeat_n+1) busy cycles, plus 1 DONE cycle.
- exp_q: each posedge, exp_q <= (dut_rst ? 0 : d_out). This models an ideal D flop with synchronous active-high reset.
- abort=1 in RESET or SHIFT: next state is IDLE, with no done pulse, d_out=0 and dut_rst=1.
- abort is ignored in IDLE and DONE.
- If start and abort are both high in IDLE, start wins.
- start while busy or in DONE is ignored; no queuing.
- Latched inputs may change freely during a run without effect.

Optional Feature:
- Macro FF_STIM_LFSR_EN.
- When defined:
  - Adds input port lfsr_sel (1 bit), latched on start.
  - If latched lfsr_sel=1, SHIFT takes d_out from a 16-bit Galois LFSR, taps 0xB400, shifting right each SHIFT cycle, output = bit 0.
  - The LFSR is seeded to 0xACE1 on every accepted start and never reaches zero.
  - Pass length, repeats, abort and done behave identically to pattern mode.
- When undefined: the lfsr_sel port does not exist, no LFSR logic is present, and d_out always comes from pattern.

Test Plan:
1. rst=0 for 3 cycles, then rst=1, idle 5 cycles -> d_out=0, dut_rst=1, busy=0, done=0, exp_q=0 throughout.
2. pattern=8'hA5, repeat_n=0, hold_n=2, one start pulse ->
   - dut_rst high 2 cycles.
   - d_out sequence 1,0,1,0,0,1,0,1.
   - exp_q shows the same sequence one cycle later.
   - done pulses once 10 cycles after the first RESET cycle.
3. pattern=8'hF0, repeat_n=2, hold_n=0 -> 1 reset cycle, then 24 back-to-back bits (11110000 x3) with no gap, then a single done.
4. Abort on the 4th SHIFT cycle of a pattern=8'hFF run -> next cycle IDLE, d_out=0, dut_rst=1, no done; an immediate new start is accepted.
5. start pulsed again during SHIFT, and rst=0 asserted mid-run in a second run ->
   - The extra start is ignored.
   - The rst=0 return to IDLE is exactly as in scenario 1, with no done.
6. With FF_STIM_LFSR_EN, lfsr_sel=1, repeat_n=0 -> first 8 d_out bits equal bit 0 of successive LFSR states starting from 0xACE1. A second start reproduces the identical sequence.
